// File: rtl/ifu_bpu_pkg.sv
// Shared types and constants for the decode-stage branch predictor:
// FSM encoding, BHT counter type, reset counter value, x0/x1 indices.
package ifu_bpu_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_RS1RD = 1'b1;

   typedef logic [1:0] bht_cnt_t;

   localparam bht_cnt_t BHT_CNT_INIT = 2'b01;

   localparam int unsigned X0_IDX = 0;
   localparam int unsigned X1_IDX = 1;

endpackage

// File: rtl/ifu_bht.sv
// Branch history table of 2-bit saturating counters with one
// prediction read port and one resolved-branch update port.
module ifu_bht
   import ifu_bpu_pkg::*;
#(
   parameter int       PC_SIZE   = 32,
   parameter int       BHT_DEPTH = 64,
   parameter bht_cnt_t CNT_INIT  = BHT_CNT_INIT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PC_SIZE-1:0] rd_pc,
   output bht_cnt_t           rd_cnt,
   input  logic               wr_en,
   input  logic [PC_SIZE-1:0] wr_pc,
   input  logic               wr_taken
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   bht_cnt_t         cnt_q [BHT_DEPTH];
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   bht_cnt_t         cur_cnt;
   bht_cnt_t         nxt_cnt;
   logic             unused_pc;

   // Bit 0 of the PC never selects an entry (16-bit aligned fetch)
   assign rd_idx = rd_pc[IDX_W:1];
   assign wr_idx = wr_pc[IDX_W:1];

   assign unused_pc = ^{rd_pc[PC_SIZE-1:IDX_W+1], rd_pc[0],
                        wr_pc[PC_SIZE-1:IDX_W+1], wr_pc[0]};

   // Read returns the registered value, so a same-cycle update is not seen
   assign rd_cnt  = cnt_q[rd_idx];
   assign cur_cnt = cnt_q[wr_idx];

   always_comb begin
      nxt_cnt = cur_cnt;
      if (wr_taken) begin
         if (cur_cnt != 2'b11) nxt_cnt = 2'(cur_cnt + 2'd1);
      end else begin
         if (cur_cnt != 2'b00) nxt_cnt = 2'(cur_cnt - 2'd1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) cnt_q[i] <= CNT_INIT;
      end else if (wr_en) begin
         cnt_q[wr_idx] <= nxt_cnt;
      end
   end

endmodule

// File: rtl/ifu_dbpu.sv
// Decode-stage branch predictor: jal/jalr/bxx direction and target
// adder operands, with a one-cycle regfile read for jalr rs1.
module ifu_dbpu
   import ifu_bpu_pkg::*;
#(
   parameter int       PC_SIZE   = 32,
   parameter int       XLEN      = 32,
   parameter int       RFIDX_W   = 5,
   parameter int       BHT_DEPTH = 64,
   parameter bit       BHT_EN    = 1'b1,
   parameter bht_cnt_t CNT_INIT  = 2'b01
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PC_SIZE-1:0] pc,
   input  logic               dec_i_valid,
   input  logic               dec_jal,
   input  logic               dec_jalr,
   input  logic               dec_bxx,
   input  logic [XLEN-1:0]    dec_bjp_imm,
   input  logic [RFIDX_W-1:0] dec_jalr_rs1idx,
   input  logic               jalr_x1_dep,
   input  logic               jalr_rs1xn_dep,
   input  logic               flush,
   input  logic [XLEN-1:0]    rf2bpu_x1,
   input  logic [XLEN-1:0]    rf2bpu_rs1,
   input  logic               upd_valid,
   input  logic [PC_SIZE-1:0] upd_pc,
   input  logic               upd_taken,
   output logic               bpu_busy,
   output logic               bpu2rf_rs1_ena,
   output logic               prdt_taken,
   output logic [PC_SIZE-1:0] prdt_pc_add_op1,
   output logic [PC_SIZE-1:0] prdt_pc_add_op2
);

   logic [0:0] state_q;
   logic [0:0] state_d;
   bht_cnt_t   bht_cnt;
   logic       dir;
   logic       rs1_x0;
   logic       rs1_x1;
   logic       rs1_xn;
   logic       rd_set;
   logic       unused_cnt;

   ifu_bht #(
      .PC_SIZE   (PC_SIZE),
      .BHT_DEPTH (BHT_DEPTH),
      .CNT_INIT  (CNT_INIT)
   ) u_bht (
      .clk      (clk),
      .rst      (rst),
      .rd_pc    (pc),
      .rd_cnt   (bht_cnt),
      .wr_en    (upd_valid),
      .wr_pc    (upd_pc),
      .wr_taken (upd_taken)
   );

   assign unused_cnt = bht_cnt[0];

   assign dir = BHT_EN ? bht_cnt[1] : dec_bjp_imm[XLEN-1];
   assign prdt_taken = dec_jal | dec_jalr | (dec_bxx & dir);

   assign rs1_x0 = (dec_jalr_rs1idx == RFIDX_W'(X0_IDX));
   assign rs1_x1 = (dec_jalr_rs1idx == RFIDX_W'(X1_IDX));
   assign rs1_xn = ~rs1_x0 & ~rs1_x1;

   always_comb begin
      prdt_pc_add_op1 = PC_SIZE'(rf2bpu_rs1);
      if (dec_bxx | dec_jal)     prdt_pc_add_op1 = pc;
      else if (dec_jalr & rs1_x0) prdt_pc_add_op1 = '0;
      else if (dec_jalr & rs1_x1) prdt_pc_add_op1 = PC_SIZE'(rf2bpu_x1);
   end

   generate
      if (PC_SIZE <= XLEN) begin : g_op2_trunc
         assign prdt_pc_add_op2 = dec_bjp_imm[PC_SIZE-1:0];
      end else begin : g_op2_sext
         assign prdt_pc_add_op2 =
            {{(PC_SIZE-XLEN){dec_bjp_imm[XLEN-1]}}, dec_bjp_imm};
      end
   endgenerate

   // Gating with rst keeps the handshake quiet while the FSM is held
   assign rd_set = ~rst & (state_q == ST_IDLE) & dec_i_valid
                 & dec_jalr & rs1_xn & ~jalr_rs1xn_dep & ~flush;

   assign bpu2rf_rs1_ena = rd_set;

   assign bpu_busy = ~rst & dec_i_valid & dec_jalr
                   & ((rs1_x1 & jalr_x1_dep)
                    | (rs1_xn & jalr_rs1xn_dep)
                    | rd_set);

   // RS1RD always lasts one cycle, so flush needs no extra term
   always_comb begin
      state_d = ST_IDLE;
      if ((state_q == ST_IDLE) && rd_set) state_d = ST_RS1RD;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

endmodule

// File: tb/tb_ifu_dbpu.sv
// Self-checking bench for ifu_dbpu: per-cycle model compare plus
// hand-computed directed expectations.
module tb_ifu_dbpu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc = '0;
   logic        dec_i_valid = 1'b0;
   logic        dec_jal = 1'b0;
   logic        dec_jalr = 1'b0;
   logic        dec_bxx = 1'b0;
   logic [31:0] dec_bjp_imm = '0;
   logic [4:0]  dec_jalr_rs1idx = '0;
   logic        jalr_x1_dep = 1'b0;
   logic        jalr_rs1xn_dep = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] rf2bpu_x1 = 32'h3000;
   logic [31:0] rf2bpu_rs1 = 32'h2000;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;

   logic        busy, ena, taken;
   logic [31:0] op1, op2;
   logic        busy_s, ena_s, taken_s;
   logic [31:0] op1_s, op2_s;

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;

   int m_cnt [64];
   bit m_rd;

   always #5 clk = ~clk;

   ifu_dbpu #(.BHT_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid),
      .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_bxx(dec_bxx),
      .dec_bjp_imm(dec_bjp_imm), .dec_jalr_rs1idx(dec_jalr_rs1idx),
      .jalr_x1_dep(jalr_x1_dep), .jalr_rs1xn_dep(jalr_rs1xn_dep),
      .flush(flush), .rf2bpu_x1(rf2bpu_x1), .rf2bpu_rs1(rf2bpu_rs1),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .bpu_busy(busy), .bpu2rf_rs1_ena(ena), .prdt_taken(taken),
      .prdt_pc_add_op1(op1), .prdt_pc_add_op2(op2)
   );

   ifu_dbpu #(.BHT_EN(1'b0)) dut_s (
      .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid),
      .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_bxx(dec_bxx),
      .dec_bjp_imm(dec_bjp_imm), .dec_jalr_rs1idx(dec_jalr_rs1idx),
      .jalr_x1_dep(jalr_x1_dep), .jalr_rs1xn_dep(jalr_rs1xn_dep),
      .flush(flush), .rf2bpu_x1(rf2bpu_x1), .rf2bpu_rs1(rf2bpu_rs1),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .bpu_busy(busy_s), .bpu2rf_rs1_ena(ena_s), .prdt_taken(taken_s),
      .prdt_pc_add_op1(op1_s), .prdt_pc_add_op2(op2_s)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   function automatic bit m_read_req();
      return !rst && !m_rd && dec_i_valid && dec_jalr
             && dec_jalr_rs1idx > 1 && !jalr_rs1xn_dep && !flush;
   endfunction

   // Model: counter table and "read in progress" flag
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         foreach (m_cnt[i]) m_cnt[i] = 1;
         m_rd = 1'b0;
      end else begin
         bit rq;
         int ui;
         rq = m_read_req();
         if (upd_valid) begin
            ui = (upd_pc / 2) % 64;
            if (upd_taken) m_cnt[ui] = (m_cnt[ui] >= 3) ? 3 : m_cnt[ui] + 1;
            else           m_cnt[ui] = (m_cnt[ui] <= 0) ? 0 : m_cnt[ui] - 1;
         end
         m_rd = rq;
      end
   end

   always @(negedge clk) begin
      if (run) begin
         bit rq, e_busy, e_tk, e_tks;
         logic [31:0] e_op1;
         rq = m_read_req();
         e_busy = !rst && dec_i_valid && dec_jalr
                  && ((dec_jalr_rs1idx == 1 && jalr_x1_dep)
                   || (dec_jalr_rs1idx > 1 && jalr_rs1xn_dep) || rq);
         e_tk  = dec_jal || dec_jalr
                 || (dec_bxx && m_cnt[(pc / 2) % 64] >= 2);
         e_tks = dec_jal || dec_jalr || (dec_bxx && dec_bjp_imm[31]);
         if (dec_bxx || dec_jal)                       e_op1 = pc;
         else if (dec_jalr && dec_jalr_rs1idx == 0)    e_op1 = 0;
         else if (dec_jalr && dec_jalr_rs1idx == 1)    e_op1 = rf2bpu_x1;
         else                                          e_op1 = rf2bpu_rs1;
         chk("m_busy", {31'b0, busy}, {31'b0, e_busy});
         chk("m_ena", {31'b0, ena}, {31'b0, rq});
         chk("m_taken", {31'b0, taken}, {31'b0, e_tk});
         chk("m_taken_s", {31'b0, taken_s}, {31'b0, e_tks});
         chk("m_op1", op1, e_op1);
         chk("m_op2", op2, dec_bjp_imm);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      dec_i_valid = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
      dec_bjp_imm = 0; dec_jalr_rs1idx = 0; jalr_x1_dep = 0;
      jalr_rs1xn_dep = 0; flush = 0; upd_valid = 0; upd_taken = 0;
   endtask

   task automatic bxx_at(logic [31:0] p);
      idle_in();
      dec_i_valid = 1; dec_bxx = 1; pc = p; dec_bjp_imm = 32'h40;
   endtask

   task automatic jalr_at(logic [4:0] r);
      idle_in();
      dec_i_valid = 1; dec_jalr = 1; dec_jalr_rs1idx = r;
   endtask

   initial begin
      #1 rst = 1'b1;
      run = 1'b1;
      // Reset-time prediction, dynamic and static
      bxx_at(32'h100);
      dec_bjp_imm = 32'hFFFF_FFF0;
      @(negedge clk);
      chk("rst_dyn_taken", {31'b0, taken}, 32'd0);
      chk("rst_sta_taken", {31'b0, taken_s}, 32'd1);
      jalr_at(5);
      @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_ena", {31'b0, ena}, 32'd0);
      step();
      rst = 1'b0;
      idle_in();
      step();

      // Two taken updates: 1 -> 3
      upd_valid = 1; upd_pc = 32'h100; upd_taken = 1;
      step(); step();
      bxx_at(32'h100);
      @(negedge clk);
      chk("after_2t", {31'b0, taken}, 32'd1);
      // Four not-taken updates: 3 -> 0, stays 0
      for (int i = 0; i < 4; i++) begin
         step();
         upd_valid = 1; upd_pc = 32'h100; upd_taken = 0;
      end
      step();
      upd_valid = 1; upd_taken = 1;
      step();
      upd_valid = 0;
      @(negedge clk);
      chk("sat_zero", {31'b0, taken}, 32'd0);

      // Same-index update and predict with counter = 1
      step();
      bxx_at(32'h100);
      upd_valid = 1; upd_pc = 32'h100; upd_taken = 1;
      @(negedge clk);
      chk("bypass_old", {31'b0, taken}, 32'd0);
      step();
      upd_valid = 0;
      @(negedge clk);
      chk("bypass_new", {31'b0, taken}, 32'd1);

      // jalr x5 regfile read sequence
      step();
      jalr_at(5);
      @(negedge clk);
      chk("jalr_c0_ena", {31'b0, ena}, 32'd1);
      chk("jalr_c0_busy", {31'b0, busy}, 32'd1);
      step();
      @(negedge clk);
      chk("jalr_c1_busy", {31'b0, busy}, 32'd0);
      chk("jalr_c1_ena", {31'b0, ena}, 32'd0);
      chk("jalr_c1_op1", op1, 32'h2000);
      step();
      @(negedge clk);
      chk("jalr_c2_idle", {31'b0, ena}, 32'd1);

      // jalr x1 dependency
      step();
      jalr_at(1); jalr_x1_dep = 1;
      @(negedge clk);
      chk("x1_dep_busy", {31'b0, busy}, 32'd1);
      chk("x1_dep_ena", {31'b0, ena}, 32'd0);
      step();
      jalr_x1_dep = 0;
      @(negedge clk);
      chk("x1_busy", {31'b0, busy}, 32'd0);
      chk("x1_op1", op1, 32'h3000);

      // jalr x0 and jal
      step();
      jalr_at(0);
      @(negedge clk);
      chk("x0_op1", op1, 32'd0);
      chk("x0_busy", {31'b0, busy}, 32'd0);
      step();
      idle_in();
      dec_i_valid = 1; dec_jal = 1; pc = 32'h80; dec_bjp_imm = 32'h10;
      @(negedge clk);
      chk("jal_op1", op1, 32'h80);
      chk("jal_op2", op2, 32'h10);
      chk("jal_taken", {31'b0, taken}, 32'd1);

      // Flush in RS1RD
      step();
      jalr_at(7);
      step();
      flush = 1;
      step();
      flush = 0;
      @(negedge clk);
      chk("flush_idle", {31'b0, ena}, 32'd1);

      // Invalid decode and rs1xn dependency
      step();
      jalr_at(6); dec_i_valid = 0;
      @(negedge clk);
      chk("inval_busy", {31'b0, busy}, 32'd0);
      step();
      jalr_at(6); jalr_rs1xn_dep = 1;
      @(negedge clk);
      chk("xn_dep_busy", {31'b0, busy}, 32'd1);
      chk("xn_dep_ena", {31'b0, ena}, 32'd0);

      // Reset while in RS1RD, with a pending update
      step();
      jalr_at(9);
      step();
      upd_valid = 1; upd_pc = 32'h100; upd_taken = 0;
      rst = 1;
      @(negedge clk);
      chk("rst_rd_ena", {31'b0, ena}, 32'd0);
      step();
      rst = 0;
      bxx_at(32'h100);
      @(negedge clk);
      chk("rst_rd_cnt", {31'b0, taken}, 32'd0);

      // Mixed traffic checked by the model
      for (int i = 0; i < 300; i++) begin
         step();
         dec_i_valid     = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: begin dec_jal = 1; dec_jalr = 0; dec_bxx = 0; end
            1: begin dec_jal = 0; dec_jalr = 1; dec_bxx = 0; end
            default: begin dec_jal = 0; dec_jalr = 0; dec_bxx = 1; end
         endcase
         pc              = {24'b0, 8'($urandom_range(0, 255))};
         dec_bjp_imm     = $urandom;
         dec_jalr_rs1idx = 5'($urandom_range(0, 4));
         jalr_x1_dep     = ($urandom_range(0, 3) == 0);
         jalr_rs1xn_dep  = ($urandom_range(0, 3) == 0);
         flush           = ($urandom_range(0, 7) == 0);
         rf2bpu_rs1      = $urandom;
         rf2bpu_x1       = $urandom;
         upd_valid       = 1'($urandom_range(0, 1));
         upd_pc          = {24'b0, 8'($urandom_range(0, 255))};
         upd_taken       = 1'($urandom_range(0, 1));
      end
      step();
      idle_in();
      @(negedge clk);
      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
